// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB encodings and types for the two-master arbiter.
// Master index is a single bit: 0 = M0, 1 = M1.
package ahb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RSP_OKAY  = 2'b00,
    RSP_ERROR = 2'b01
  } hresp_e;

  typedef logic mst_idx_t;

  function automatic logic [1:0] onehot(mst_idx_t i);
    return i ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle between two AHB masters, the arbiter and one slave.
// The arbiter uses the master modport (it masters the slave side).
interface ahb_master_arbiter_if #(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH    = 32
);

  logic [1:0]                   m_busreq;
  logic [1:0][1:0]              m_HTRANS;
  logic [1:0][ADDRESSWIDTH-1:0] m_HADDR;
  logic [1:0]                   m_HWRITE;
  logic [1:0][2:0]              m_HSIZE;
  logic [1:0][2:0]              m_HBURST;
  logic [1:0][3:0]              m_HPROT;
  logic [1:0][DATAWIDTH-1:0]    m_HWDATA;
  logic [1:0]                   m_HGRANT;
  logic [1:0]                   m_HREADY;
  logic [1:0][1:0]              m_HRESP;
  logic [1:0][DATAWIDTH-1:0]    m_HRDATA;

  logic [1:0]              HTRANS;
  logic [ADDRESSWIDTH-1:0] HADDR;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [3:0]              HPROT;
  logic [DATAWIDTH-1:0]    HWDATA;
  logic                    HSEL;
  logic                    HREADY;
  logic [1:0]              HRESP;
  logic [DATAWIDTH-1:0]    HRDATA;

  modport master (
    input  m_busreq, m_HTRANS, m_HADDR, m_HWRITE,
    input  m_HSIZE, m_HBURST, m_HPROT, m_HWDATA,
    output m_HGRANT, m_HREADY, m_HRESP, m_HRDATA,
    output HTRANS, HADDR, HWRITE, HSIZE, HBURST,
    output HPROT, HWDATA, HSEL,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    output m_busreq, m_HTRANS, m_HADDR, m_HWRITE,
    output m_HSIZE, m_HBURST, m_HPROT, m_HWDATA,
    input  m_HGRANT, m_HREADY, m_HRESP, m_HRDATA,
    input  HTRANS, HADDR, HWRITE, HSIZE, HBURST,
    input  HPROT, HWDATA, HSEL,
    output HREADY, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_rr_arbiter.sv
// Two-way round-robin picker; parks on the current owner when idle.
module ahb_rr_arbiter
  import ahb_master_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_owner,
  input  mst_idx_t   cur_owner,
  output mst_idx_t   winner
);

  always_comb begin
    winner = cur_owner;
    unique case (1'b1)
      (req == 2'b11): winner = ~last_owner;
      (req == 2'b01): winner = 1'b0;
      (req == 2'b10): winner = 1'b1;
      default:        winner = cur_owner;
    endcase
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB arbiter with address/data ownership pipeline,
// hold limit, error-forced re-arbitration and round-robin choice.
module ahb_master_arbiter
  import ahb_master_arbiter_pkg::*;
#(
  parameter int ADDRESSWIDTH = 32,
  parameter int DATAWIDTH    = 32,
  parameter int MAX_HOLD     = 16
) (
  input logic            clk,
  input logic            reset_n,
  ahb_master_arbiter_if.master bus
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  mst_idx_t        addr_owner, addr_owner_d;
  mst_idx_t        data_owner, data_owner_d;
  mst_idx_t        last_owner, last_owner_d;
  logic [CW-1:0]   hold_cnt, hold_d;
  logic            parked, parked_d;
  logic            started, started_d;

  mst_idx_t        winner;
  logic [1:0]      own_trans;
  logic [1:0]      eff_trans;
  logic            stale;
  logic            beat;
  logic            cond_a, cond_b, cond_c;
  logic            rearb;

  logic [ADDRESSWIDTH-1:0] haddr;
  logic [DATAWIDTH-1:0]    hwdata;

  ahb_rr_arbiter u_rr (
    .req        (bus.m_busreq),
    .last_owner (last_owner),
    .cur_owner  (addr_owner),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_owner <= 1'b0;
      data_owner <= 1'b0;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      parked     <= 1'b1;
      started    <= 1'b0;
    end else begin
      addr_owner <= addr_owner_d;
      data_owner <= data_owner_d;
      last_owner <= last_owner_d;
      hold_cnt   <= hold_d;
      parked     <= parked_d;
      started    <= started_d;
    end
  end

  // A new owner's SEQ/BUSY before its own NONSEQ is a leftover
  // of an interrupted burst and must not reach the slave.
  always_comb begin
    own_trans = bus.m_HTRANS[addr_owner];
    stale = !started &&
            (own_trans == TR_SEQ || own_trans == TR_BUSY);
    eff_trans = stale ? TR_IDLE : own_trans;
    beat = (eff_trans == TR_NONSEQ) ||
           (eff_trans == TR_SEQ);

    cond_a = (eff_trans == TR_IDLE) &&
             !bus.m_busreq[addr_owner];
    cond_b = (hold_cnt == HOLD_MAX) &&
             bus.m_busreq[~addr_owner] &&
             (eff_trans == TR_NONSEQ ||
              eff_trans == TR_IDLE);
    cond_c = (bus.HRESP == RSP_ERROR);
    // A parked grant is open to any new request.
    rearb = bus.HREADY &&
            (cond_a || cond_b || cond_c ||
             (parked && |bus.m_busreq));
  end

  always_comb begin
    addr_owner_d = addr_owner;
    data_owner_d = data_owner;
    last_owner_d = last_owner;
    hold_d       = hold_cnt;
    parked_d     = parked;
    started_d    = started;
    if (bus.HREADY) begin
      data_owner_d = addr_owner;
      if (eff_trans == TR_NONSEQ)
        started_d = 1'b1;
      if (beat && hold_cnt != HOLD_MAX)
        hold_d = hold_cnt + 1'b1;
      if (rearb) begin
        addr_owner_d = winner;
        last_owner_d = winner;
        parked_d     = ~|bus.m_busreq;
        if (winner != addr_owner) begin
          hold_d    = '0;
          started_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    haddr  = bus.m_HADDR[addr_owner];
    hwdata = bus.m_HWDATA[data_owner];

    bus.m_HGRANT = onehot(addr_owner);
    bus.m_HREADY = {2{bus.HREADY}};
    bus.m_HRESP  = '0;
    bus.m_HRDATA = '0;
    bus.m_HRESP[data_owner]  = bus.HRESP;
    bus.m_HRDATA[data_owner] = bus.HRDATA;

    bus.HTRANS = eff_trans;
    bus.HADDR  = haddr;
    bus.HWRITE = bus.m_HWRITE[addr_owner];
    bus.HSIZE  = bus.m_HSIZE[addr_owner];
    bus.HBURST = bus.m_HBURST[addr_owner];
    bus.HPROT  = bus.m_HPROT[addr_owner];
    bus.HWDATA = hwdata;
    bus.HSEL   = 1'b1;
  end

endmodule
